// File: rtl/modulation_pkg.sv
// Shared constants and the debug state decode for the segment modulator.
package modulation_pkg;
  localparam int NUM_SEG     = 10;
  localparam int WORD_W      = 32;
  localparam int VALID_COUNT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/modulation_pack.sv
// Combinational pack of NUM_SEG masked segments into one word, LSB-first.
// Optional even parity in bit 31 when MODULATION_PARITY_EN is defined.
module modulation_pack
  import modulation_pkg::*;
#(
  parameter int SEG_W = 3
) (
  input  logic [NUM_SEG*SEG_W-1:0] seg_flat,
  output logic [WORD_W-1:0]        word
);

  always_comb begin
    word = '0;
    word[NUM_SEG*SEG_W-1:0] = seg_flat;
`ifdef MODULATION_PARITY_EN
    word[WORD_W-1] = ^word[WORD_W-2:0];
`endif
  end

endmodule

// File: rtl/modulation_segment_5_with_control.sv
// Segment modulator: mask/pack ten segments through a 3-stage pipe, with a start/valid/busy counter.
// Build option MODULATION_PARITY_EN puts even parity into bit_out[31].
module modulation_segment_5_with_control
  import modulation_pkg::*;
#(
  parameter int SEG_W   = 3,
  parameter int COUNT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] segment_0,
  input  logic [31:0] segment_1,
  input  logic [31:0] segment_2,
  input  logic [31:0] segment_3,
  input  logic [31:0] segment_4,
  input  logic [31:0] segment_5,
  input  logic [31:0] segment_6,
  input  logic [31:0] segment_7,
  input  logic [31:0] segment_8,
  input  logic [31:0] segment_9,
  input  logic        start,
  output logic [31:0] bit_out,
  output logic        valid,
  output logic        busy
);

  localparam int SEGS_W = NUM_SEG * SEG_W;
  localparam logic [COUNT_W-1:0] CNT_DONE = COUNT_W'(VALID_COUNT);

  logic [SEGS_W-1:0]  seg_d, seg_q;
  logic [WORD_W-1:0]  word_d, word_q;
  logic [WORD_W-1:0]  bit_out_d, bit_out_q;
  logic [COUNT_W-1:0] count_d, count_q;
  logic               start_seen_d, start_seen_q;
  state_e             state;
  logic               unused_seg_hi;

  assign unused_seg_hi = ^{segment_0[31:SEG_W], segment_1[31:SEG_W], segment_2[31:SEG_W],
                           segment_3[31:SEG_W], segment_4[31:SEG_W], segment_5[31:SEG_W],
                           segment_6[31:SEG_W], segment_7[31:SEG_W], segment_8[31:SEG_W],
                           segment_9[31:SEG_W]};

  modulation_pack #(.SEG_W(SEG_W)) u_pack (
    .seg_flat (seg_q),
    .word     (word_d)
  );

  always_comb begin
    seg_d = {segment_9[SEG_W-1:0], segment_8[SEG_W-1:0], segment_7[SEG_W-1:0],
             segment_6[SEG_W-1:0], segment_5[SEG_W-1:0], segment_4[SEG_W-1:0],
             segment_3[SEG_W-1:0], segment_2[SEG_W-1:0], segment_1[SEG_W-1:0],
             segment_0[SEG_W-1:0]};
    bit_out_d = word_q;
  end

  // Counting starts one edge after start is first seen, so DONE lands on the
  // same edge as the word built from segments captured on the first count edge.
  always_comb begin
    start_seen_d = start;
    count_d      = count_q;
    if (!start) begin
      count_d = '0;
    end else if (start_seen_q && (count_q != CNT_DONE)) begin
      count_d = count_q + COUNT_W'(1);
    end

    state = RUN;
    if (count_q == '0) begin
      state = IDLE;
    end else if (count_q == CNT_DONE) begin
      state = DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q        <= '0;
      word_q       <= '0;
      bit_out_q    <= '0;
      count_q      <= '0;
      start_seen_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      word_q       <= word_d;
      bit_out_q    <= bit_out_d;
      count_q      <= count_d;
      start_seen_q <= start_seen_d;
    end
  end

  assign bit_out = bit_out_q;
  assign valid   = (state == DONE);
  assign busy    = !valid;

endmodule
